// File: rtl/l2c_pkg.sv
// Shared defaults, lowest-set-bit selector and read-tracking entry layout
// for the L2 SRAM access sequencer.
package l2c_pkg;

    localparam int unsigned NCH_DEF      = 6;
    localparam int unsigned AW_DEF       = 18;
    localparam int unsigned LW_DEF       = 4;
    localparam int unsigned RQ_DEPTH_DEF = 4;
    localparam int unsigned CW_DEF       = $clog2(NCH_DEF);

    // One outstanding read burst: owning channel and length minus one
    typedef struct packed {
        logic [CW_DEF-1:0] ch;
        logic [LW_DEF-1:0] len;
    } rd_entry_t;

    // Index of the lowest set bit; 0 when no bit is set
    function automatic logic [4:0] lowest_set(input logic [31:0] v);
        lowest_set = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) lowest_set = 5'(i);
        end
    endfunction

endpackage

// File: rtl/l2c_rd_fifo.sv
// Synchronous FIFO tracking outstanding read bursts; a push and a pop in
// the same cycle are both honoured.
module l2c_rd_fifo #(
    parameter int unsigned W     = 7,
    parameter int unsigned DEPTH = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [PW:0]  wr_q, wr_d;
    logic [PW:0]  rd_q, rd_d;
    logic         do_push;
    logic         do_pop;

    // Extra pointer bit distinguishes full from empty
    assign o_empty = (wr_q == rd_q);
    assign o_full  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign o_data  = mem_q[rd_q[PW-1:0]];

    always_comb begin
        do_pop  = i_pop & ~o_empty;
        do_push = i_push & (~o_full | do_pop);
        wr_d    = wr_q;
        rd_d    = rd_q;
        if (do_push) wr_d = wr_q + (PW+1)'(1);
        if (do_pop)  rd_d = rd_q + (PW+1)'(1);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (do_push) mem_q[wr_q[PW-1:0]] <= i_data;
    end

endmodule

// File: rtl/l2c_sram_seq.sv
// L2 SRAM access sequencer: turns one-hot channel selections into wrapping
// word bursts on the SRAM controller and reports per-channel start/end.
module l2c_sram_seq
    import l2c_pkg::*;
#(
    parameter int unsigned NCH      = NCH_DEF,
    parameter int unsigned AW       = AW_DEF,
    parameter int unsigned LW       = LW_DEF,
    parameter int unsigned RQ_DEPTH = RQ_DEPTH_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [NCH-1:0]    i_sel,
    input  logic              i_sel_valid,
    output logic              o_sel_stall,
    input  logic [NCH*AW-1:0] i_req_adr,
    input  logic [NCH-1:0]    i_req_we,
    input  logic [NCH*4-1:0]  i_req_be,
    input  logic [NCH*LW-1:0] i_req_len,
    output logic [NCH-1:0]    o_start,
    output logic [NCH-1:0]    o_end,
    output logic [AW-1:0]     o_sctl_req_adr,
    output logic              o_sctl_req_we,
    output logic [3:0]        o_sctl_req_be,
    output logic              o_sctl_req_valid,
    input  logic              i_sctl_req_stall,
    input  logic              i_sctl_resp_valid,
    output logic              o_resp_err
);

    localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned BW = AW - LW - 2;
    localparam int unsigned EW = CW + LW;

    typedef enum logic {ST_IDLE, ST_ISSUE} state_e;

    typedef struct packed {
        logic [CW-1:0] ch;
        logic [LW-1:0] len;
    } rd_ent_t;

    state_e        state_q, state_d;
    logic [CW-1:0] ch_q, ch_d;
    logic [BW-1:0] base_q, base_d;
    logic [LW-1:0] off_q, off_d;
    logic [LW-1:0] rem_q, rem_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [3:0]    be_q, be_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;

    logic [CW-1:0] sel_idx;
    logic [AW-3:0] sel_wadr;
    logic          sel_we;
    logic [3:0]    sel_be;
    logic [LW-1:0] sel_len;

    logic          consume, last_beat, can_take, accept, push, pop, resp_hit;
    rd_ent_t       push_ent, head;
    logic [EW-1:0] head_raw;
    logic          fifo_full, fifo_empty;
    logic [NCH-1:0] start_c, end_c;

    // Selected channel's request fields (word address only)
    assign sel_idx  = CW'(lowest_set(32'(i_sel)));
    assign sel_wadr = i_req_adr[sel_idx*AW + 2 +: AW-2];
    assign sel_we   = i_req_we[sel_idx];
    assign sel_be   = i_req_be[sel_idx*4 +: 4];
    assign sel_len  = i_req_len[sel_idx*LW +: LW];

    assign head     = rd_ent_t'(head_raw);
    assign push_ent = '{ch: sel_idx, len: sel_len};

    always_comb begin
        consume   = valid_q & ~i_sctl_req_stall;
        last_beat = consume & (rem_q == '0);
        can_take  = ((state_q == ST_IDLE) | last_beat) & (sel_we | ~fifo_full);
        accept    = i_sel_valid & can_take;
        push      = accept & ~sel_we;
        resp_hit  = i_sctl_resp_valid & ~fifo_empty;
        pop       = resp_hit & (cnt_q == head.len);
    end

    // Issue FSM and beat sequencing
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        base_d  = base_q;
        off_d   = off_q;
        rem_d   = rem_q;
        we_d    = we_q;
        be_d    = be_q;
        valid_d = valid_q;
        if (accept) begin
            state_d = ST_ISSUE;
            valid_d = 1'b1;
            ch_d    = sel_idx;
            base_d  = sel_wadr[AW-3:LW];
            off_d   = sel_wadr[LW-1:0];
            rem_d   = sel_len;
            we_d    = sel_we;
            be_d    = sel_we ? sel_be : 4'hF;
        end else if (last_beat) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
        end else if (consume) begin
            off_d = off_q + LW'(1);
            rem_d = rem_q - LW'(1);
        end
    end

    // Read response tracking and error flag
    always_comb begin
        cnt_d = cnt_q;
        if (resp_hit) cnt_d = pop ? '0 : cnt_q + LW'(1);
        err_d = err_q | (i_sctl_resp_valid & fifo_empty);
    end

    // Start/end pulses from write issue and read returns
    always_comb begin
        start_c = '0;
        end_c   = '0;
        if (accept & sel_we)        start_c = start_c | (NCH'(1) << sel_idx);
        if (last_beat & we_q)       end_c   = end_c | (NCH'(1) << ch_q);
        if (resp_hit & (cnt_q == '0)) start_c = start_c | (NCH'(1) << head.ch);
        if (pop)                    end_c   = end_c | (NCH'(1) << head.ch);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            base_q  <= '0;
            off_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            be_q    <= 4'h0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            base_q  <= base_d;
            off_q   <= off_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            be_q    <= be_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    l2c_rd_fifo #(
        .W     (EW),
        .DEPTH (RQ_DEPTH)
    ) u_rd_fifo (
        .Clk     (Clk),
        .Reset   (Reset),
        .i_push  (push),
        .i_data  (push_ent),
        .i_pop   (pop),
        .o_data  (head_raw),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    assign o_sel_stall      = ~can_take;
    assign o_start          = Reset ? '0 : start_c;
    assign o_end            = Reset ? '0 : end_c;
    assign o_sctl_req_adr   = {base_q, off_q, 2'b00};
    assign o_sctl_req_we    = we_q;
    assign o_sctl_req_be    = be_q;
    assign o_sctl_req_valid = valid_q;
    assign o_resp_err       = err_q;

endmodule

// File: tb/tb_l2c_sram_seq.sv
// Scoreboard bench for l2c_sram_seq: directed bursts push expected beats and
// start/end pulses; a negedge monitor pops and compares them.
module tb_l2c_sram_seq;

    localparam int unsigned NCH = 6;
    localparam int unsigned AW  = 18;
    localparam int unsigned LW  = 4;
    localparam int unsigned RQ  = 4;

    logic              Clk = 1'b0;
    logic              Reset;
    logic [NCH-1:0]    i_sel;
    logic              i_sel_valid;
    logic              o_sel_stall;
    logic [NCH*AW-1:0] i_req_adr;
    logic [NCH-1:0]    i_req_we;
    logic [NCH*4-1:0]  i_req_be;
    logic [NCH*LW-1:0] i_req_len;
    logic [NCH-1:0]    o_start;
    logic [NCH-1:0]    o_end;
    logic [AW-1:0]     o_sctl_req_adr;
    logic              o_sctl_req_we;
    logic [3:0]        o_sctl_req_be;
    logic              o_sctl_req_valid;
    logic              i_sctl_req_stall;
    logic              i_sctl_resp_valid;
    logic              o_resp_err;

    always #5 Clk = ~Clk;

    l2c_sram_seq #(.NCH(NCH), .AW(AW), .LW(LW), .RQ_DEPTH(RQ)) dut (
        .Clk               (Clk),
        .Reset             (Reset),
        .i_sel             (i_sel),
        .i_sel_valid       (i_sel_valid),
        .o_sel_stall       (o_sel_stall),
        .i_req_adr         (i_req_adr),
        .i_req_we          (i_req_we),
        .i_req_be          (i_req_be),
        .i_req_len         (i_req_len),
        .o_start           (o_start),
        .o_end             (o_end),
        .o_sctl_req_adr    (o_sctl_req_adr),
        .o_sctl_req_we     (o_sctl_req_we),
        .o_sctl_req_be     (o_sctl_req_be),
        .o_sctl_req_valid  (o_sctl_req_valid),
        .i_sctl_req_stall  (i_sctl_req_stall),
        .i_sctl_resp_valid (i_sctl_resp_valid),
        .o_resp_err        (o_resp_err)
    );

    typedef struct {
        logic [AW-1:0] adr;
        logic          we;
        logic [3:0]    be;
    } beat_t;

    typedef struct {
        logic [NCH-1:0] st;
        logic [NCH-1:0] en;
    } ev_t;

    beat_t beat_q[$];
    ev_t   ev_q[$];
    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every consumed beat and every pulse is matched against the queues
    always @(negedge Clk) begin : monitor
        beat_t b;
        ev_t   e;
        if (mon_en && !Reset) begin
            if (o_sctl_req_valid && !i_sctl_req_stall) begin
                if (beat_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got adr %h expected none at %0t", o_sctl_req_adr, $time);
                end else begin
                    b = beat_q.pop_front();
                    chk("beat_adr", 32'(o_sctl_req_adr), 32'(b.adr));
                    chk("beat_we",  32'(o_sctl_req_we),  32'(b.we));
                    chk("beat_be",  32'(o_sctl_req_be),  32'(b.be));
                end
            end
            if ((o_start | o_end) != '0) begin
                if (ev_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: got start %b end %b expected none at %0t", o_start, o_end, $time);
                end else begin
                    e = ev_q.pop_front();
                    chk("pulse_start", 32'(o_start), 32'(e.st));
                    chk("pulse_end",   32'(o_end),   32'(e.en));
                end
            end
        end
    end

    task automatic set_req(input int ch, input logic [AW-1:0] adr, input logic we,
                           input logic [3:0] be, input logic [LW-1:0] len);
        i_req_adr[ch*AW +: AW] = adr;
        i_req_we[ch]           = we;
        i_req_be[ch*4 +: 4]    = be;
        i_req_len[ch*LW +: LW] = len;
    endtask

    // Expected beats: same line, word offset wrapping modulo 16
    task automatic push_burst(input logic [AW-1:0] adr, input logic we,
                              input logic [3:0] be, input int len);
        beat_t b;
        int    off;
        for (int i = 0; i <= len; i++) begin
            off   = ((int'(adr) >> 2) + i) % 16;
            b.adr = (adr & 18'h3FFC0) | AW'(off * 4);
            b.we  = we;
            b.be  = we ? be : 4'hF;
            beat_q.push_back(b);
        end
    endtask

    task automatic push_ev(input logic [NCH-1:0] st, input logic [NCH-1:0] en);
        ev_t e;
        e.st = st;
        e.en = en;
        ev_q.push_back(e);
    endtask

    // Present a selection until it is accepted (bounded)
    task automatic issue(input int ch);
        int n = 0;
        @(posedge Clk);
        #1;
        i_sel       = NCH'(1) << ch;
        i_sel_valid = 1'b1;
        forever begin
            @(negedge Clk);
            if (!o_sel_stall) break;
            n++;
            if (n > 100) begin
                checks++;
                errors++;
                $display("FAIL issue_timeout: got stall %b expected accept on ch %0d", o_sel_stall, ch);
                break;
            end
        end
        @(posedge Clk);
        #1;
        i_sel_valid = 1'b0;
        i_sel       = '0;
    endtask

    task automatic resp(input int n);
        @(posedge Clk);
        #1;
        i_sctl_resp_valid = 1'b1;
        repeat (n) @(posedge Clk);
        #1;
        i_sctl_resp_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (beat_q.size() != 0 && n < 200) begin
            @(posedge Clk);
            n++;
        end
        if (beat_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d beats pending expected 0", beat_q.size());
        end
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        Reset             = 1'b1;
        i_sel             = '0;
        i_sel_valid       = 1'b0;
        i_req_adr         = '0;
        i_req_we          = '0;
        i_req_be          = '0;
        i_req_len         = '0;
        i_sctl_req_stall  = 1'b0;
        i_sctl_resp_valid = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b0;
        @(negedge Clk);
        chk("rst_valid", 32'(o_sctl_req_valid), 32'd0);
        chk("rst_adr",   32'(o_sctl_req_adr),   32'd0);
        chk("rst_we",    32'(o_sctl_req_we),    32'd0);
        chk("rst_be",    32'(o_sctl_req_be),    32'd0);
        chk("rst_start", 32'(o_start),          32'd0);
        chk("rst_end",   32'(o_end),            32'd0);
        chk("rst_err",   32'(o_resp_err),       32'd0);
        chk("rst_stall", 32'(o_sel_stall),      32'd0);
        mon_en = 1'b1;

        // 16-beat write, ch 0
        set_req(0, 18'h00040, 1'b1, 4'hF, 4'd15);
        push_burst(18'h00040, 1'b1, 4'hF, 15);
        push_ev(6'b000001, 6'b000000);
        push_ev(6'b000000, 6'b000001);
        issue(0);
        wait_drain();

        // Wrapping read, ch 2, offset 14, 8 beats then 8 responses
        set_req(2, 18'h000B8, 1'b0, 4'h5, 4'd7);
        push_burst(18'h000B8, 1'b0, 4'hF, 7);
        issue(2);
        wait_drain();
        push_ev(6'b000100, 6'b000000);
        push_ev(6'b000000, 6'b000100);
        resp(8);
        @(negedge Clk);

        // Four single-word reads fill the tracking FIFO
        set_req(1, 18'h00404, 1'b0, 4'hF, 4'd0);
        set_req(3, 18'h00408, 1'b0, 4'hF, 4'd0);
        set_req(5, 18'h0040C, 1'b0, 4'hF, 4'd0);
        push_burst(18'h00404, 1'b0, 4'hF, 0);
        issue(1);
        push_burst(18'h00408, 1'b0, 4'hF, 0);
        issue(3);
        push_burst(18'h0040C, 1'b0, 4'hF, 0);
        issue(5);
        push_burst(18'h00404, 1'b0, 4'hF, 0);
        issue(1);
        wait_drain();
        set_req(2, 18'h00500, 1'b0, 4'hF, 4'd0);
        i_sel = 6'b000100;
        @(negedge Clk);
        chk("fifo_full_stall", 32'(o_sel_stall), 32'd1);
        push_ev(6'b000010, 6'b000010);
        resp(1);
        @(negedge Clk);
        chk("fifo_pop_unstall", 32'(o_sel_stall), 32'd0);
        i_sel = '0;
        push_ev(6'b001000, 6'b001000);
        push_ev(6'b100000, 6'b100000);
        push_ev(6'b000010, 6'b000010);
        resp(3);
        @(negedge Clk);

        // Write len 3 with back-pressure on beat 1 for 3 cycles
        set_req(3, 18'h00100, 1'b1, 4'hC, 4'd3);
        push_burst(18'h00100, 1'b1, 4'hC, 3);
        push_ev(6'b001000, 6'b000000);
        push_ev(6'b000000, 6'b001000);
        issue(3);
        @(posedge Clk);
        #1;
        i_sctl_req_stall = 1'b1;
        repeat (3) begin
            @(negedge Clk);
            chk("stall_adr",   32'(o_sctl_req_adr),   32'h00104);
            chk("stall_be",    32'(o_sctl_req_be),    32'hC);
            chk("stall_valid", 32'(o_sctl_req_valid), 32'd1);
            @(posedge Clk);
        end
        #1;
        i_sctl_req_stall = 1'b0;
        wait_drain();

        // Back-to-back: read ch 4 len 1, write ch 0 accepted on its last beat
        set_req(4, 18'h00200, 1'b0, 4'hF, 4'd1);
        set_req(0, 18'h00300, 1'b1, 4'h3, 4'd0);
        push_burst(18'h00200, 1'b0, 4'hF, 1);
        issue(4);
        push_burst(18'h00300, 1'b1, 4'h3, 0);
        push_ev(6'b000001, 6'b000000);
        push_ev(6'b000000, 6'b000001);
        issue(0);
        @(negedge Clk);
        chk("b2b_valid", 32'(o_sctl_req_valid), 32'd1);
        chk("b2b_we",    32'(o_sctl_req_we),    32'd1);
        chk("b2b_be",    32'(o_sctl_req_be),    32'h3);
        chk("b2b_adr",   32'(o_sctl_req_adr),   32'h00300);
        @(posedge Clk);
        #1;
        @(negedge Clk);
        chk("b2b_valid_drop", 32'(o_sctl_req_valid), 32'd0);
        push_ev(6'b010000, 6'b000000);
        push_ev(6'b000000, 6'b010000);
        resp(2);
        @(negedge Clk);

        // Response with nothing outstanding
        chk("err_before", 32'(o_resp_err), 32'd0);
        resp(1);
        @(negedge Clk);
        chk("err_sticky", 32'(o_resp_err), 32'd1);

        chk("beat_q_empty", 32'(beat_q.size()), 32'd0);
        chk("ev_q_empty",   32'(ev_q.size()),   32'd0);

        // Reset mid-burst aborts everything
        mon_en = 1'b0;
        set_req(1, 18'h00040, 1'b1, 4'hF, 4'd15);
        issue(1);
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        chk("abort_valid", 32'(o_sctl_req_valid), 32'd0);
        chk("abort_adr",   32'(o_sctl_req_adr),   32'd0);
        chk("abort_we",    32'(o_sctl_req_we),    32'd0);
        chk("abort_be",    32'(o_sctl_req_be),    32'd0);
        chk("abort_err",   32'(o_resp_err),       32'd0);
        chk("abort_end",   32'(o_end),            32'd0);
        #1;
        Reset = 1'b0;
        @(negedge Clk);
        chk("abort_idle_valid", 32'(o_sctl_req_valid), 32'd0);
        chk("abort_idle_end",   32'(o_end),            32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
